mux_rr_reg: RTL and testbench

Parametrised N-channel, WIDTH-bit registered selector with valid/ready handshaking on every input and on the output. It generalises the 2:1 16-bit datapath mux to N sources and adds an output pipeline register with backpressure. Selection is either software-fixed (`sel`) or round-robin. It sits between operand/result producers and a shared consumer inside the CPU datapath.

---
 rtl/mux_rr_reg.sv | 112 +++++++++++
 tb/tb_mux_rr_reg.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_rr_reg.sv
// N-channel registered selector with valid/ready on every input and on the output.
// The grant is either a fixed select index or round-robin after the last mode-1 winner.
module mux_rr_reg #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned N     = 4,
   parameter int unsigned SELW  = $clog2(N)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N*WIDTH-1:0]   in_data,
   input  logic [N-1:0]         in_valid,
   output logic [N-1:0]         in_ready,
   input  logic                 mode,
   input  logic [SELW-1:0]      sel,
   output logic [WIDTH-1:0]     out_data,
   output logic [SELW-1:0]      out_src,
   output logic                 out_valid,
   input  logic                 out_ready
);

   // The pointer starts at the last channel so that channel 0 wins the first round-robin scan.
   localparam logic [SELW-1:0] PtrRst = SELW'(N - 1);

   logic [WIDTH-1:0] data_q, data_d;
   logic [SELW-1:0]  src_q, src_d;
   logic             valid_q, valid_d;
   logic [SELW-1:0]  ptr_q, ptr_d;

   logic             load;
   logic             grant_valid;
   logic [SELW-1:0]  grant;
   logic [WIDTH-1:0] grant_data;

   assign load = !valid_q || out_ready;

   always_comb begin : grant_logic
      grant       = '0;
      grant_valid = 1'b0;
      if (!mode) begin
         // An out-of-range sel matches no loop index, so it never grants.
         for (int unsigned i = 0; i < N; i++) begin
            if (sel == SELW'(i) && in_valid[i]) begin
               grant       = SELW'(i);
               grant_valid = 1'b1;
            end
         end
      end else begin
         for (int unsigned k = 1; k <= N; k++) begin
            for (int unsigned i = 0; i < N; i++) begin
               if (!grant_valid && in_valid[i] && (((32'(ptr_q) + k) % N) == i)) begin
                  grant       = SELW'(i);
                  grant_valid = 1'b1;
               end
            end
         end
      end
   end

   always_comb begin : data_mux
      grant_data = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (grant == SELW'(i)) begin
            grant_data = in_data[i*WIDTH +: WIDTH];
         end
      end
   end

   always_comb begin : ready_logic
      in_ready = '0;
      for (int unsigned i = 0; i < N; i++) begin
         in_ready[i] = rst_n && load && grant_valid && (grant == SELW'(i));
      end
   end

   always_comb begin : next_state
      data_d  = data_q;
      src_d   = src_q;
      valid_d = valid_q;
      ptr_d   = ptr_q;
      if (load) begin
         if (grant_valid) begin
            data_d  = grant_data;
            src_d   = grant;
            valid_d = 1'b1;
            if (mode) begin
               ptr_d = grant;
            end
         end else begin
            valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q  <= '0;
         src_q   <= '0;
         valid_q <= 1'b0;
         ptr_q   <= PtrRst;
      end else begin
         data_q  <= data_d;
         src_q   <= src_d;
         valid_q <= valid_d;
         ptr_q   <= ptr_d;
      end
   end

   assign out_data  = data_q;
   assign out_src   = src_q;
   assign out_valid = valid_q;

endmodule

// File: tb/tb_mux_rr_reg.sv
// Bench for mux_rr_reg: directed scenarios plus a random soak against a behavioural model
// and an in-order scoreboard. A second, 3-channel instance covers the out-of-range select.
module tb_mux_rr_reg;

   localparam int W = 16;
   localparam int N = 4;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [N*W-1:0] in_data = '0;
   logic [N-1:0]   in_valid = '0;
   logic [N-1:0]   in_ready;
   logic           mode = 1'b0;
   logic [1:0]     sel = '0;
   logic [W-1:0]   out_data;
   logic [1:0]     out_src;
   logic           out_valid;
   logic           out_ready = 1'b0;

   logic [3*W-1:0] in_data3;
   logic [2:0]     in_valid3;
   logic [2:0]     in_ready3;
   logic [W-1:0]   out_data3;
   logic [1:0]     out_src3;
   logic           out_valid3;

   assign in_data3  = in_data[3*W-1:0];
   assign in_valid3 = in_valid[2:0];

   int n_cmp = 0;
   int n_err = 0;

   // Behavioural model: output register contents and the last round-robin winner.
   int           m_ptr;
   bit           m_valid;
   logic [W-1:0] m_data;
   int           m_src;

   always #5 clk = ~clk;

   mux_rr_reg #(.WIDTH(W), .N(N)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .mode      (mode),
      .sel       (sel),
      .out_data  (out_data),
      .out_src   (out_src),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   mux_rr_reg #(.WIDTH(W), .N(3)) u_dut3 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data3),
      .in_valid  (in_valid3),
      .in_ready  (in_ready3),
      .mode      (mode),
      .sel       (sel),
      .out_data  (out_data3),
      .out_src   (out_src3),
      .out_valid (out_valid3),
      .out_ready (out_ready)
   );

   function automatic int exp_grant();
      if (!mode) begin
         if (int'(sel) < N && in_valid[sel]) return int'(sel);
         return -1;
      end
      for (int k = 1; k <= N; k++) begin
         if (in_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
      end
      return -1;
   endfunction

   function automatic logic [N-1:0] exp_ready();
      logic [N-1:0] one = 4'b0001;
      int g = exp_grant();
      if (rst_n && (!m_valid || out_ready) && g >= 0) return one << g;
      return '0;
   endfunction

   task automatic model_reset();
      m_ptr   = N - 1;
      m_valid = 1'b0;
      m_data  = '0;
      m_src   = 0;
   endtask

   // Advance one clock; the model sees the same inputs the DUT sees at the edge.
   task automatic tick();
      int g = exp_grant();
      bit ld = !m_valid || out_ready;
      @(posedge clk);
      if (rst_n && ld) begin
         if (g >= 0) begin
            m_valid = 1'b1;
            m_data  = in_data[g*W +: W];
            m_src   = g;
            if (mode) m_ptr = g;
         end else begin
            m_valid = 1'b0;
         end
      end
      #1;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      model_reset();
      #2;
      rst_n = 1'b1;
   endtask

   task automatic set_all(input logic [W-1:0] d0, input logic [W-1:0] d1,
                          input logic [W-1:0] d2, input logic [W-1:0] d3);
      in_data = {d3, d2, d1, d0};
   endtask

   task automatic test_reset();
      model_reset();
      mode      = 1'b1;
      out_ready = 1'b1;
      in_valid  = 4'hF;
      set_all(16'h0000, 16'h1111, 16'h2222, 16'h3333);
      #2;
      n_cmp++;
      if (out_valid !== 1'b0 || out_data !== '0 || out_src !== '0) begin
         n_err++;
         $display("FAIL reset_init got v=%b d=%h s=%0d exp 0/0000/0", out_valid, out_data, out_src);
      end
      n_cmp++;
      if (in_ready !== 4'b0000) begin
         n_err++;
         $display("FAIL reset_init_ready got %b exp 0000", in_ready);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick();
      tick();
      n_cmp++;
      if (out_valid !== 1'b1 || out_src !== 2'd1) begin
         n_err++;
         $display("FAIL reset_prerun got v=%b s=%0d exp 1/1", out_valid, out_src);
      end
      #1;
      rst_n = 1'b0;
      model_reset();
      #1;
      n_cmp++;
      if (out_valid !== 1'b0 || out_data !== '0 || out_src !== '0 || in_ready !== '0) begin
         n_err++;
         $display("FAIL reset_mid got v=%b d=%h s=%0d r=%b exp all zero",
                  out_valid, out_data, out_src, in_ready);
      end
      #1;
      rst_n = 1'b1;
      tick();
      n_cmp++;
      if (out_valid !== 1'b1 || out_src !== 2'd0 || out_data !== 16'h0000) begin
         n_err++;
         $display("FAIL reset_first_rr got v=%b s=%0d d=%h exp 1/0/0000", out_valid, out_src,
                  out_data);
      end
   endtask

   task automatic test_fixed_select();
      mode      = 1'b0;
      sel       = 2'd2;
      out_ready = 1'b1;
      in_valid  = 4'hF;
      set_all(16'($urandom), 16'($urandom), 16'hA5A5, 16'($urandom));
      #1;
      n_cmp++;
      if (in_ready !== 4'b0100) begin
         n_err++;
         $display("FAIL fixed_ready got %b exp 0100", in_ready);
      end
      tick();
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== 16'hA5A5 || out_src !== 2'd2) begin
         n_err++;
         $display("FAIL fixed_out got v=%b d=%h s=%0d exp 1/a5a5/2", out_valid, out_data, out_src);
      end
      in_valid = 4'b1011;
      #1;
      n_cmp++;
      if (in_ready !== 4'b0000) begin
         n_err++;
         $display("FAIL fixed_drop_ready got %b exp 0000", in_ready);
      end
      tick();
      n_cmp++;
      if (out_valid !== 1'b0 || out_data !== 16'hA5A5) begin
         n_err++;
         $display("FAIL fixed_drop got v=%b d=%h exp 0/a5a5", out_valid, out_data);
      end
   endtask

   task automatic test_round_robin();
      do_reset();
      mode      = 1'b1;
      out_ready = 1'b1;
      in_valid  = 4'hF;
      set_all(16'h0000, 16'h1111, 16'h2222, 16'h3333);
      for (int k = 0; k < 8; k++) begin
         tick();
         n_cmp++;
         if (out_valid !== 1'b1 || int'(out_src) != k % 4 || out_data !== 16'(16'h1111 * (k % 4)))
         begin
            n_err++;
            $display("FAIL rr_all[%0d] got v=%b s=%0d d=%h exp src %0d", k, out_valid, out_src,
                     out_data, k % 4);
         end
      end
      in_valid = 4'b1010;
      for (int k = 0; k < 4; k++) begin
         tick();
         n_cmp++;
         if (int'(out_src) != ((k % 2 == 0) ? 1 : 3) || out_src !== 2'(m_src)) begin
            n_err++;
            $display("FAIL rr_odd[%0d] got s=%0d exp %0d", k, out_src, (k % 2 == 0) ? 1 : 3);
         end
      end
   endtask

   task automatic test_backpressure();
      mode      = 1'b0;
      sel       = 2'd0;
      out_ready = 1'b1;
      in_valid  = 4'hF;
      set_all(16'h1234, 16'($urandom), 16'($urandom), 16'($urandom));
      tick();
      out_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         in_data = {$urandom, $urandom};
         #1;
         n_cmp++;
         if (in_ready !== 4'b0000 || out_valid !== 1'b1 || out_data !== 16'h1234 ||
             out_src !== 2'd0) begin
            n_err++;
            $display("FAIL bp_stall[%0d] got r=%b v=%b d=%h s=%0d exp 0000/1/1234/0", k, in_ready,
                     out_valid, out_data, out_src);
         end
         tick();
      end
      out_ready = 1'b1;
      set_all(16'hBEEF, 16'($urandom), 16'($urandom), 16'($urandom));
      #1;
      n_cmp++;
      if (in_ready !== 4'b0001) begin
         n_err++;
         $display("FAIL bp_release_ready got %b exp 0001", in_ready);
      end
      tick();
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== 16'hBEEF) begin
         n_err++;
         $display("FAIL bp_release_out got v=%b d=%h exp 1/beef", out_valid, out_data);
      end
   endtask

   task automatic test_out_of_range();
      mode      = 1'b0;
      sel       = 2'd1;
      out_ready = 1'b1;
      in_valid  = 4'hF;
      set_all(16'($urandom), 16'h7E57, 16'($urandom), 16'($urandom));
      tick();
      n_cmp++;
      if (out_valid3 !== 1'b1 || out_data3 !== 16'h7E57 || out_src3 !== 2'd1) begin
         n_err++;
         $display("FAIL oor_setup got v=%b d=%h s=%0d exp 1/7e57/1", out_valid3, out_data3,
                  out_src3);
      end
      sel = 2'd3;
      #1;
      n_cmp++;
      if (in_ready3 !== 3'b000) begin
         n_err++;
         $display("FAIL oor_ready got %b exp 000", in_ready3);
      end
      tick();
      n_cmp++;
      if (out_valid3 !== 1'b0) begin
         n_err++;
         $display("FAIL oor_valid got %b exp 0", out_valid3);
      end
   endtask

   task automatic test_mode_switch();
      do_reset();
      mode      = 1'b1;
      out_ready = 1'b1;
      in_valid  = 4'hF;
      set_all(16'hC0C0, 16'hC1C1, 16'hC2C2, 16'hC3C3);
      for (int k = 0; k < 3; k++) begin
         tick();
         n_cmp++;
         if (int'(out_src) != k) begin
            n_err++;
            $display("FAIL ms_rr[%0d] got s=%0d exp %0d", k, out_src, k);
         end
      end
      mode = 1'b0;
      sel  = 2'd0;
      for (int k = 0; k < 3; k++) begin
         tick();
         n_cmp++;
         if (out_src !== 2'd0 || out_data !== 16'hC0C0) begin
            n_err++;
            $display("FAIL ms_fixed[%0d] got s=%0d d=%h exp 0/c0c0", k, out_src, out_data);
         end
      end
      mode = 1'b1;
      #1;
      n_cmp++;
      if (in_ready !== 4'b1000) begin
         n_err++;
         $display("FAIL ms_back_ready got %b exp 1000", in_ready);
      end
      tick();
      n_cmp++;
      if (out_src !== 2'd3 || out_data !== 16'hC3C3) begin
         n_err++;
         $display("FAIL ms_back got s=%0d d=%h exp 3/c3c3", out_src, out_data);
      end
   endtask

   task automatic test_soak();
      logic [17:0] q[$];
      logic [17:0] front;
      int          bad = 0;
      do_reset();
      q.delete();
      for (int c = 0; c < 2000; c++) begin
         in_valid  = 4'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         mode      = 1'($urandom_range(0, 1));
         sel       = 2'($urandom_range(0, 3));
         in_data   = {$urandom, $urandom};
         #1;
         n_cmp++;
         if (in_ready !== exp_ready() || $countones(in_ready) > 1) begin
            n_err++;
            bad++;
            if (bad < 10) $display("FAIL soak_ready[%0d] got %b exp %b", c, in_ready, exp_ready());
         end
         n_cmp++;
         if (out_valid !== m_valid || (m_valid && (out_data !== m_data || out_src !== 2'(m_src))))
         begin
            n_err++;
            bad++;
            if (bad < 10) $display("FAIL soak_out[%0d] got v=%b d=%h s=%0d exp %b/%h/%0d", c,
                                   out_valid, out_data, out_src, m_valid, m_data, m_src);
         end
         if (out_valid && out_ready) begin
            n_cmp++;
            if (q.size() == 0) begin
               n_err++;
               bad++;
               if (bad < 10) $display("FAIL soak_sb_empty[%0d] got output %h exp none", c, out_data);
            end else begin
               front = q.pop_front();
               if ({out_src, out_data} !== front) begin
                  n_err++;
                  bad++;
                  if (bad < 10) $display("FAIL soak_sb[%0d] got %h exp %h", c, {out_src, out_data},
                                         front);
               end
            end
         end
         for (int i = 0; i < N; i++) begin
            if (in_valid[i] && in_ready[i]) q.push_back({2'(i), in_data[i*W +: W]});
         end
         tick();
      end
      n_cmp++;
      if (q.size() != (out_valid ? 1 : 0)) begin
         n_err++;
         $display("FAIL soak_sb_left got %0d pending exp %0d", q.size(), out_valid ? 1 : 0);
      end
   endtask

   initial begin
      test_reset();
      test_fixed_select();
      test_round_robin();
      test_backpressure();
      test_out_of_range();
      test_mode_switch();
      test_soak();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog got timeout exp completion");
      $fatal(1, "watchdog");
   end

endmodule
